// File: rtl/fb_write_engine.sv
// -----------------------------------------------------------------------------
// fb_write_engine
//
// Command-driven write engine for a WIDTH x HEIGHT framebuffer with
// COLOR_BITS-bit pixels. Accepts PIXEL, RECT-fill and CLEAR commands over a
// valid/ready handshake and rasterises each one into framebuffer writes,
// one write per clock, in x-fastest raster order.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  engine can accept a command (idle and not signalling done)
//   cmd_op     00 PIXEL, 01 RECT, 10 CLEAR, 11 reserved (rejected)
//   cmd_x0     PIXEL x / RECT left column
//   cmd_y0     PIXEL y / RECT top line
//   cmd_x1     RECT right column, inclusive
//   cmd_y1     RECT bottom line, inclusive
//   cmd_color  colour to write
//   fb_waddr   framebuffer write address {y, x}
//   fb_din     framebuffer write data
//   fb_we      framebuffer write strobe
//   busy       high from the cycle after acceptance through the done cycle
//   done       one-cycle pulse when a command completes
//   err        qualifies done: 1 = command rejected, nothing written
//
// Timing (command accepted at edge T, N writes):
//   writes visible after edges T+1..T+N, done after T+N+1, cmd_ready after
//   T+N+2. A rejected command behaves as N=0.
// -----------------------------------------------------------------------------
module fb_write_engine #(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int COLOR_BITS = 4,
  parameter int ADDR_BITS  = 12,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [XW-1:0]         cmd_x0,
  input  logic [YW-1:0]         cmd_y0,
  input  logic [XW-1:0]         cmd_x1,
  input  logic [YW-1:0]         cmd_y1,
  input  logic [COLOR_BITS-1:0] cmd_color,
  output logic [ADDR_BITS-1:0]  fb_waddr,
  output logic [COLOR_BITS-1:0] fb_din,
  output logic                  fb_we,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [1:0] OP_PIXEL = 2'b00;
  localparam logic [1:0] OP_RECT  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Captured command and raster position
  logic [XW-1:0]         x_reg, x0_reg, x1_reg;
  logic [YW-1:0]         y_reg, y1_reg;
  logic [COLOR_BITS-1:0] color_reg;
  logic                  rej_reg;

  // Registered outputs
  logic [ADDR_BITS-1:0]  waddr_reg, waddr_next;
  logic [COLOR_BITS-1:0] din_reg, din_next;
  logic                  we_reg, we_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;

  logic accept;
  logic reject_cmd;
  logic last_px;

  // Ready is withheld during the done cycle as well, so a new command can
  // only be taken one cycle after done has been seen.
  assign cmd_ready = (state_reg == S_IDLE) && !done_reg;
  assign accept    = cmd_valid && cmd_ready;

  assign reject_cmd = (cmd_op == 2'b11) ||
                      ((cmd_op == OP_RECT) && ((cmd_x1 < cmd_x0) || (cmd_y1 < cmd_y0)));

  // Compared before any increment, so the counters never step past x1/y1.
  assign last_px = (x_reg == x1_reg) && (y_reg == y1_reg);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = reject_cmd ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_px) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered outputs. Each WRITE cycle
  // presents the current raster position; the write becomes visible one edge
  // later, which is what shifts done/ready by one cycle after the last write.
  // ---------------------------------------------------------------------------
  always_comb begin
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    din_next   = din_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    busy_next  = (state_next != S_IDLE) || (state_reg == S_DONE);
    case (state_reg)
      S_WRITE: begin
        we_next    = 1'b1;
        waddr_next = {y_reg, x_reg};
        din_next   = color_reg;
      end
      S_DONE: begin
        done_next = 1'b1;
        err_next  = rej_reg;
      end
      default: begin
        we_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_reg <= '0;
      din_reg   <= '0;
      we_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      waddr_reg <= waddr_next;
      din_reg   <= din_next;
      we_reg    <= we_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  assign fb_waddr = waddr_reg;
  assign fb_din   = din_reg;
  assign fb_we    = we_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

  // ---------------------------------------------------------------------------
  // Command capture and raster counters. PIXEL and CLEAR are normalised into
  // rectangles at capture so the walk below only ever handles one shape.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg     <= '0;
      y_reg     <= '0;
      x0_reg    <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      color_reg <= '0;
      rej_reg   <= 1'b0;
    end else if (accept) begin
      color_reg <= cmd_color;
      rej_reg   <= reject_cmd;
      case (cmd_op)
        OP_CLEAR: begin
          x_reg  <= '0;
          y_reg  <= '0;
          x0_reg <= '0;
          x1_reg <= X_MAX;
          y1_reg <= Y_MAX;
        end
        OP_PIXEL: begin
          x_reg  <= cmd_x0;
          y_reg  <= cmd_y0;
          x0_reg <= cmd_x0;
          x1_reg <= cmd_x0;
          y1_reg <= cmd_y0;
        end
        default: begin
          x_reg  <= cmd_x0;
          y_reg  <= cmd_y0;
          x0_reg <= cmd_x0;
          x1_reg <= cmd_x1;
          y1_reg <= cmd_y1;
        end
      endcase
    end else if ((state_reg == S_WRITE) && !last_px) begin
      if (x_reg == x1_reg) begin
        // End of a line: y < y1 here, so y+1 cannot overflow.
        x_reg <= x0_reg;
        y_reg <= y_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_write_engine.sv
module tb_fb_write_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [3:0]  cmd_color;
  logic [11:0] fb_waddr;
  logic [3:0]  fb_din;
  logic        fb_we, busy, done, err;

  int checks = 0;
  int passes = 0;

  // Scoreboard: expected writes as addr*16+colour, expected err per done
  int exp_wq[$];
  bit exp_dq[$];

  always #5 clk = ~clk;

  fb_write_engine dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .fb_waddr(fb_waddr), .fb_din(fb_din), .fb_we(fb_we),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d required %0d", nm, act, exp);
  endtask

  // Monitor: pops and compares whenever the DUT presents a write or a done
  always @(negedge clk) begin
    int e;
    bit eb;
    if (!rst) begin
      if (fb_we && done) chk("we_with_done", 1, 0);
      if (fb_we) begin
        if (exp_wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_wq.pop_front();
          chk("write_addr", int'(fb_waddr), e / 16);
          chk("write_din", int'(fb_din), e % 16);
        end
      end
      if (done) begin
        if (exp_dq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          eb = exp_dq.pop_front();
          chk("done_err", int'(err), int'(eb));
        end
      end
    end
  end

  // Reference model: the set of pixels a command paints, in raster order
  task automatic model(input int op, input int x0, input int y0, input int x1,
                       input int y1, input int color, output int n);
    bit rej;
    int xa, xb, ya, yb;
    rej = (op == 3) || (op == 1 && (x1 < x0 || y1 < y0));
    n = 0;
    if (!rej) begin
      if (op == 0) begin xa = x0; xb = x0; ya = y0; yb = y0; end
      else if (op == 1) begin xa = x0; xb = x1; ya = y0; yb = y1; end
      else begin xa = 0; xb = 63; ya = 0; yb = 63; end
      for (int y = ya; y <= yb; y++)
        for (int x = xa; x <= xb; x++) begin
          exp_wq.push_back((y * 64 + x) * 16 + color);
          n++;
        end
    end
    exp_dq.push_back(rej);
  endtask

  task automatic drive_fields(input int op, input int x0, input int y0,
                              input int x1, input int y1, input int color);
    cmd_op    = op[1:0];
    cmd_x0    = x0[5:0];
    cmd_y0    = y0[5:0];
    cmd_x1    = x1[5:0];
    cmd_y1    = y1[5:0];
    cmd_color = color[3:0];
  endtask

  task automatic drive_noise();
    drive_fields($urandom_range(0, 3), $urandom_range(0, 63), $urandom_range(0, 63),
                 $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 15));
  endtask

  // Called at a negedge with the engine ready. With noise set, cmd_valid stays
  // high with random fields while busy and on return.
  task automatic run_cmd(input string tag, input int op, input int x0, input int y0,
                         input int x1, input int y1, input int color, input bit noise);
    int n, k, wr, first_k;
    chk({tag, "_ready_before"}, int'(cmd_ready), 1);
    drive_fields(op, x0, y0, x1, y1, color);
    cmd_valid = 1'b1;
    model(op, x0, y0, x1, y1, color, n);
    $display("cmd %s op=%0d (%0d,%0d)-(%0d,%0d) color=%0d writes=%0d", tag, op, x0, y0,
             x1, y1, color, n);
    @(posedge clk);
    #1;
    if (noise) drive_noise();
    else cmd_valid = 1'b0;
    k = 0; wr = 0; first_k = -1;
    forever begin
      @(negedge clk);
      if (k == 0) begin
        chk({tag, "_busy_after_accept"}, int'(busy), 1);
        chk({tag, "_ready_while_busy"}, int'(cmd_ready), 0);
      end
      if (fb_we) begin
        wr++;
        if (first_k < 0) first_k = k;
      end
      if (done) break;
      if (k > n + 10) begin
        chk({tag, "_done_timeout"}, 1, 0);
        break;
      end
      k++;
      if (noise) drive_noise();
    end
    chk({tag, "_done_latency"}, k, n + 1);
    chk({tag, "_write_count"}, wr, n);
    if (n > 0) chk({tag, "_first_write"}, first_k, 1);
    chk({tag, "_busy_at_done"}, int'(busy), 1);
    chk({tag, "_ready_at_done"}, int'(cmd_ready), 0);
    @(negedge clk);
    chk({tag, "_ready_after_done"}, int'(cmd_ready), 1);
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, wr, x0, y0, x1, y1, t, r;
    rst = 1'b1;
    cmd_valid = 1'b0;
    drive_fields(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_fb_waddr", int'(fb_waddr), 0);
    chk("rst_fb_din", int'(fb_din), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);

    // Directed cases
    run_cmd("pixel", 0, 5, 40, 17, 3, 'hA, 1'b0);
    run_cmd("rect", 1, 2, 3, 4, 4, 'h7, 1'b0);
    run_cmd("clear", 2, 9, 9, 1, 1, 'h3, 1'b0);
    run_cmd("rect_rej", 1, 10, 5, 9, 6, 'h5, 1'b0);
    run_cmd("op11_rej", 3, 1, 1, 2, 2, 'h5, 1'b0);
    run_cmd("rect_yrej", 1, 4, 8, 6, 7, 'h9, 1'b0);
    run_cmd("rect_corner", 1, 60, 61, 63, 63, 'hF, 1'b0);

    // Back-to-back with changing fields held valid during busy
    run_cmd("b2b_a", 1, 20, 30, 23, 31, 'h1, 1'b1);
    run_cmd("b2b_b", 0, 63, 63, 0, 0, 'h2, 1'b1);
    run_cmd("b2b_c", 1, 0, 62, 2, 63, 'hC, 1'b0);

    // CLEAR aborted by reset one cycle after the 100th write
    chk("abort_ready", int'(cmd_ready), 1);
    drive_fields(2, 0, 0, 0, 0, 'h6);
    cmd_valid = 1'b1;
    model(2, 0, 0, 0, 0, 'h6, n);
    $display("cmd abort_clear op=2 color=6 writes=100 then rst");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wr = 0;
    for (int i = 0; i < 200 && wr < 100; i++) begin
      @(negedge clk);
      if (fb_we) wr++;
    end
    chk("abort_reached_100", wr, 100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_fb_we", int'(fb_we), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    exp_wq.delete();
    exp_dq.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", int'(cmd_ready), 1);
    chk("abort_no_write", int'(fb_we), 0);
    @(negedge clk);

    // Randomised commands
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      x0 = $urandom_range(0, 63);
      y0 = $urandom_range(0, 63);
      x1 = x0 + $urandom_range(0, 7); if (x1 > 63) x1 = 63;
      y1 = y0 + $urandom_range(0, 5); if (y1 > 63) y1 = 63;
      if (r >= 4 && r <= 8 && $urandom_range(0, 5) == 0 && x1 != x0) begin
        t = x0; x0 = x1; x1 = t;
      end
      if (r <= 3)
        run_cmd("rnd_pixel", 0, x0, y0, $urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 15), (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
      else if (r <= 8)
        run_cmd("rnd_rect", 1, x0, y0, x1, y1, $urandom_range(0, 15),
                (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
      else
        run_cmd("rnd_op11", 3, x0, y0, x1, y1, $urandom_range(0, 15),
                (i < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
    end

    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("writes_drained", exp_wq.size(), 0);
    chk("dones_drained", exp_dq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
